// File: rtl/psum_par_accum_fifo.sv
// Circular partial-sum FIFO: PAR_WRITE-wide appends, PAR_READ-wide pops and
// in-place accumulation of input psums into the oldest unread entries.
module psum_par_accum_fifo #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 24,
    parameter int PAR_WRITE = 1,
    parameter int PAR_READ  = 1,
    parameter bit SATURATE  = 1,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       wen,
    input  logic                       acc_wen,
    input  logic [PAR_WRITE*WIDTH-1:0] din,
    input  logic                       ren,
    output logic [PAR_READ*WIDTH-1:0]  dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic [CNT_W-1:0]           count,
    output logic                       err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] PW_C    = CNT_W'(PAR_WRITE);
    localparam logic [CNT_W-1:0] PR_C    = CNT_W'(PAR_READ);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             acc_ok;
    logic             rd_ok;
    logic             rej;
    logic [CNT_W-1:0] count_next;

    // Both operands stay below DEPTH, so one conditional subtract is a full modulo.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr, input int step);
        int sum;
        sum = int'(ptr) + step;
        if (sum >= DEPTH) sum = sum - DEPTH;
        return PTR_W'(sum);
    endfunction

    function automatic logic [WIDTH-1:0] add_word(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] sum;
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (SATURATE && (sum[WIDTH] != sum[WIDTH-1]))
            return sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        return sum[WIDTH-1:0];
    endfunction

    // Acceptance uses the registered pre-edge flags; a flush masks every request.
    always_comb begin
        wr_ok      = !clr && wen && !full && !acc_wen;
        acc_ok     = !clr && acc_wen && (count >= PW_C) && !ren;
        rd_ok      = !clr && ren && !empty;
        rej        = !clr && ((wen && !wr_ok) || (acc_wen && !acc_ok) || (ren && !rd_ok));
        count_next = count;
        if (wr_ok) count_next = count_next + PW_C;
        if (rd_ok) count_next = count_next - PR_C;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int k = 0; k < PAR_WRITE; k++)
                mem[wrap_add(wr_ptr, k)] <= din[k*WIDTH +: WIDTH];
        end
        if (acc_ok) begin
            for (int k = 0; k < PAR_WRITE; k++)
                mem[wrap_add(rd_ptr, k)] <= add_word(mem[wrap_add(rd_ptr, k)], din[k*WIDTH +: WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wrap_add(wr_ptr, PAR_WRITE);
            if (rd_ok) begin
                rd_ptr <= wrap_add(rd_ptr, PAR_READ);
                for (int k = 0; k < PAR_READ; k++)
                    dout[k*WIDTH +: WIDTH] <= mem[wrap_add(rd_ptr, k)];
            end
            count      <= count_next;
            full       <= (DEPTH_C - count_next) < PW_C;
            empty      <= count_next < PR_C;
            dout_valid <= rd_ok;
            err        <= rej;
        end
    end
endmodule

// File: tb/tb_psum_par_accum_fifo.sv
// Scoreboard bench for psum_par_accum_fifo (WIDTH=8, DEPTH=7, PAR_WRITE=2,
// PAR_READ=3, saturating): directed corner cases followed by random traffic.
`timescale 1ns/1ps
module tb_psum_par_accum_fifo;
    localparam int W  = 8;
    localparam int D  = 7;
    localparam int PW = 2;
    localparam int PR = 3;
    localparam int CW = $clog2(D + 1);
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          wen = 1'b0;
    logic          acc_wen = 1'b0;
    logic          ren = 1'b0;
    logic [PW*W-1:0] din = '0;
    logic [PR*W-1:0] dout;
    logic          dout_valid;
    logic          full;
    logic          empty;
    logic          err;
    logic [CW-1:0] count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the FIFO contents as a plain queue of signed values, oldest first.
    int              mq[$];
    logic [PR*W-1:0] sb[$];
    logic [PR*W-1:0] hold_val = '0;
    bit              mon_en = 1'b0;
    bit              exp_err, exp_valid, exp_full, exp_empty;
    int              exp_count;

    always #5 clk = ~clk;

    psum_par_accum_fifo #(
        .WIDTH(W), .DEPTH(D), .PAR_WRITE(PW), .PAR_READ(PR), .SATURATE(1'b1), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .wen(wen), .acc_wen(acc_wen), .din(din),
        .ren(ren), .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .count(count), .err(err)
    );

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic int lane(input logic [PW*W-1:0] d, input int k);
        logic [W-1:0] b;
        b = d[k*W +: W];
        return int'($signed(b));
    endfunction

    function automatic int sat_add(input int a, input int b);
        int s;
        s = a + b;
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        return s;
    endfunction

    task automatic reset_model();
        mq.delete();
        sb.delete();
        hold_val  = '0;
        exp_count = 0;
        exp_full  = 1'b0;
        exp_empty = 1'b1;
        exp_err   = 1'b0;
        exp_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input bit w, input bit a, input bit r, input bit c, input logic [PW*W-1:0] d);
        bit full_m, empty_m, wr_ok, acc_ok, rd_ok;
        logic [PR*W-1:0] word;
        wen = w; acc_wen = a; ren = r; clr = c; din = d;
        full_m  = (D - mq.size()) < PW;
        empty_m = mq.size() < PR;
        if (c) begin
            mq.delete();
            exp_err   = 1'b0;
            exp_valid = 1'b0;
            hold_val  = '0;
        end else begin
            wr_ok  = w && !full_m && !a;
            acc_ok = a && (mq.size() >= PW) && !r;
            rd_ok  = r && !empty_m;
            exp_err   = (w && !wr_ok) || (a && !acc_ok) || (r && !rd_ok);
            exp_valid = rd_ok;
            if (acc_ok)
                for (int k = 0; k < PW; k++) mq[k] = sat_add(mq[k], lane(d, k));
            if (rd_ok) begin
                word = '0;
                for (int k = 0; k < PR; k++) word[k*W +: W] = W'(mq.pop_front());
                sb.push_back(word);
            end
            if (wr_ok)
                for (int k = 0; k < PW; k++) mq.push_back(lane(d, k));
        end
        exp_count = mq.size();
        exp_full  = (D - mq.size()) < PW;
        exp_empty = mq.size() < PR;
    endtask

    task automatic step(input bit w, input bit a, input bit r, input bit c, input logic [PW*W-1:0] d);
        apply_stimulus(w, a, r, c, d);
        @(negedge clk);
    endtask

    task automatic check_output();
        logic [PR*W-1:0] want;
        compare("count", 64'(count), 64'(exp_count));
        compare("full", 64'(full), 64'(exp_full));
        compare("empty", 64'(empty), 64'(exp_empty));
        compare("err", 64'(err), 64'(exp_err));
        compare("dout_valid", 64'(dout_valid), 64'(exp_valid));
        if (dout_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_dout: got %0h, required no read", dout);
            end else begin
                want = sb.pop_front();
                compare("dout", 64'(dout), 64'(want));
                hold_val = want;
            end
        end else begin
            compare("dout_hold", 64'(dout), 64'(hold_val));
        end
    endtask

    task automatic reset_checks(input string tag);
        compare({tag, "_count"}, 64'(count), 64'(0));
        compare({tag, "_empty"}, 64'(empty), 64'(1));
        compare({tag, "_full"}, 64'(full), 64'(0));
        compare({tag, "_dout"}, 64'(dout), 64'(0));
        compare({tag, "_valid"}, 64'(dout_valid), 64'(0));
        compare({tag, "_err"}, 64'(err), 64'(0));
    endtask

    function automatic logic [W-1:0] rand_lane();
        int v;
        case ($urandom_range(0, 3))
            0:       v = int'($urandom_range(100, SMAX));
            1:       v = -int'($urandom_range(100, -SMIN));
            default: v = int'($urandom_range(0, 255));
        endcase
        return W'(v);
    endfunction

    always @(posedge clk) begin
        #1;
        if (mon_en) check_output();
    end

    initial begin
        logic [PW*W-1:0] d;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("por");
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;

        // Fill to full, overflow, then write+read on a full FIFO.
        step(1, 0, 0, 0, {8'd2, 8'd1});
        step(1, 0, 0, 0, {8'd4, 8'd3});
        step(1, 0, 0, 0, {8'd6, 8'd5});
        compare("fill_count", 64'(count), 64'(6));
        compare("fill_full", 64'(full), 64'(1));
        step(1, 0, 0, 0, {8'd8, 8'd7});
        compare("overflow_err", 64'(err), 64'(1));
        step(1, 0, 1, 0, {8'd8, 8'd7});
        compare("wr_rd_full_count", 64'(count), 64'(3));
        compare("wr_rd_full_dout", 64'(dout), 64'({8'd3, 8'd2, 8'd1}));
        step(0, 0, 1, 0, '0);
        compare("drain_empty", 64'(empty), 64'(1));

        // Wrapped write, saturating accumulate across the wrap, acc+ren collision.
        step(1, 0, 0, 0, {8'hFD, 8'd100});
        step(1, 0, 0, 0, {8'd2, 8'd1});
        step(0, 1, 0, 0, {8'd7, 8'd50});
        step(0, 1, 1, 0, {8'd7, 8'd50});
        compare("acc_sat_dout", 64'(dout), 64'({8'd1, 8'd4, 8'd127}));
        compare("acc_ren_err", 64'(err), 64'(1));
        compare("acc_ren_count", 64'(count), 64'(1));
        step(1, 0, 0, 0, {8'h80, 8'h9C});
        step(0, 1, 0, 0, {8'hCE, 8'd5});
        step(0, 0, 1, 0, '0);
        compare("neg_sat_dout", 64'(dout), 64'({8'h80, 8'h80, 8'd7}));

        // Asynchronous reset while a read result is being presented.
        step(1, 0, 0, 0, {8'd2, 8'd1});
        step(1, 0, 0, 0, {8'd4, 8'd3});
        apply_stimulus(0, 0, 1, 0, '0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        reset_checks("async");
        reset_model();
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, '0);

        // Synchronous clear overriding every request, right after a read.
        step(1, 0, 0, 0, {8'd9, 8'd9});
        step(1, 0, 0, 0, {8'd9, 8'd9});
        step(0, 0, 1, 0, '0);
        step(1, 1, 1, 1, {8'd1, 8'd1});
        reset_checks("clr");
        step(0, 0, 0, 0, '0);

        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < PW; k++) d[k*W +: W] = rand_lane();
            step(($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 25),
                 ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 1), d);
        end
        step(0, 0, 0, 0, '0);
        compare("sb_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/psum_par_accum_fifo.md
Name: psum_par_accum_fifo

Overview:
- Parametrised successor to the single-lane partial-sum buffer in the accelerator top.
- Circular partial-sum FIFO with independent parallel write width (PAR_WRITE lanes) and parallel read width (PAR_READ lanes).
- Adds an in-place accumulate mode: input psums are summed into the oldest unread entries instead of appended (the just-add flow).
- Sits between the PE reduction network / external psum input and the output buffer.

Parameters:
- WIDTH, 32, bits per psum word (signed two's complement)
- DEPTH, 24, entries; any integer >= max(PAR_WRITE, PAR_READ), need not be a power of two
- PAR_WRITE, 1, words accepted per write/accumulate
- PAR_READ, 1, words delivered per read
- SATURATE, 1, 1 = saturating signed add, 0 = wrap modulo 2^WIDTH
- CNT_W, $clog2(DEPTH+1), width of count output

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- clr  in  1  synchronous flush, active-high
- wen  in  1  append PAR_WRITE words
- acc_wen  in  1  accumulate PAR_WRITE words in place
- din  in  PAR_WRITE*WIDTH  lane k = din[k*WIDTH +: WIDTH]
- ren  in  1  pop PAR_READ words
- dout  out  PAR_READ*WIDTH  lane k = entry rd_ptr+k at accept time
- dout_valid  out  1  one-cycle pulse, dout updated
- full  out  1  free entries < PAR_WRITE
- empty  out  1  count < PAR_READ
- count  out  CNT_W  occupied entries
- err  out  1  one-cycle pulse on any rejected request

Behaviour:
- Reset (rst low, async): wr_ptr = rd_ptr = count = 0; dout = 0; dout_valid = 0; err = 0; full = 0; empty = 1. Storage contents are don't-care.
- clr: same effect as reset, applied at the clock edge; overrides all requests that cycle; err = 0.
- Pointers advance modulo DEPTH. Lane k of a multi-word access addresses (ptr+k) mod DEPTH, wrapping mid-access.
- Write acceptance:
  - wen accepted iff !full and !acc_wen.
  - din lanes stored at wr_ptr..; wr_ptr += PAR_WRITE.
- Accumulate acceptance:
  - acc_wen accepted iff count >= PAR_WRITE and !ren.
  - Entry (rd_ptr+k) is replaced by entry + din lane k.
  - Pointers and count are unchanged.
  - SATURATE=1: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Read acceptance:
  - ren accepted iff !empty.
  - dout registered, valid the cycle after acceptance, with dout_valid = 1 for exactly that cycle.
  - rd_ptr += PAR_READ.
  - dout holds its last value when no read is accepted.
- Simultaneous requests:
  - wen + ren, both accepted: count += PAR_WRITE - PAR_READ. full/empty evaluate on pre-edge count, so a write into a full FIFO is rejected even if a read frees space that cycle.
  - wen + acc_wen: acc_wen is evaluated alone; wen is rejected (err).
  - acc_wen + ren: acc_wen is rejected (err); ren proceeds normally.
- Rejected requests: err = 1 next cycle; no state change from that request.
- Flags (full, empty) and count are registered and reflect post-edge state.
- Latency: write to readable = 1 cycle (count updates at the edge); accumulate result visible to a ren issued the next cycle.
- Reset asserted mid-operation: immediate clear; the pending dout_valid is dropped.

Test Plan:
- PAR_WRITE=1, PAR_READ=1, DEPTH=4: write 1,2,3,4 -> full=1 and count=4; a 5th write gives err pulse and count stays 4; 4 reads -> dout 1,2,3,4 with one dout_valid each, then empty=1.
- PAR_WRITE=2, PAR_READ=1, DEPTH=5: write {1,2}, {3,4} -> count=4, full=1 (free 1 < 2); read -> 1; write {5,6} wraps into entries 4 and 0; reads -> 2,3,4,5,6.
- Accumulate, SATURATE=1, WIDTH=8: write 100, -3; acc_wen with {50} (PAR_WRITE=1) -> entry 0 = 127 (saturated); read -> 127; acc_wen with 7 -> entry holds 4; read -> 4.
- SATURATE=0, WIDTH=8: entry 100 + 50 -> reads -106; entry -128 + -1 -> reads 127.
- Collisions: acc_wen+ren with count=2 -> err pulse, ren pops the old value unmodified; wen+ren on a full FIFO -> write rejected (err), read accepted, count = DEPTH-1.
- Reset/clear: rst low asynchronously between edges with count=3 and a read in flight -> count=0, empty=1, dout=0, no dout_valid afterwards; repeat with clr -> same result at the next edge.
